// File: rtl/fpu_mag_comp_seq_if.sv
// Handshake and operand bus between the adder front end (master) and the
// sequential magnitude comparator (slave).
interface fpu_mag_comp_seq_if #(
    parameter int SIZE_DATA = 32
) ();
    logic                 i_start;
    logic                 i_flush;
    logic [SIZE_DATA-1:0] i_data_a;
    logic [SIZE_DATA-1:0] i_data_b;
    logic                 o_ready;
    logic                 o_busy;
    logic                 o_valid;
    logic                 o_less;
    logic                 o_equal;

    modport master (
        output i_start, i_flush, i_data_a, i_data_b,
        input  o_ready, o_busy, o_valid, o_less, o_equal
    );

    modport slave (
        input  i_start, i_flush, i_data_a, i_data_b,
        output o_ready, o_busy, o_valid, o_less, o_equal
    );
endinterface

// File: rtl/fpu_mag_comp_seq.sv
// Sequential unsigned magnitude comparator: one 8-bit compare slice walks the
// captured operands from the most significant byte down, optionally stopping
// at the first unequal byte.
//
// state  | meaning
// S_IDLE | waiting for a start, o_ready high
// S_CMP  | comparing byte r_idx of the captured operands
// S_DONE | result registers just updated, o_valid pulse
module fpu_mag_comp_seq #(
    parameter int SIZE_DATA  = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    fpu_mag_comp_seq_if.slave   bus
);
    localparam int NUM_CHUNK = SIZE_DATA / 8;
    localparam int W_IDX     = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [W_IDX-1:0]              r_idx;
    logic [NUM_CHUNK-1:0][7:0]     r_a;
    logic [NUM_CHUNK-1:0][7:0]     r_b;
    logic                          r_seen;
    logic                          r_lt_sticky;
    logic                          r_less;
    logic                          r_equal;

    logic [7:0] w_a_byte;
    logic [7:0] w_b_byte;
    logic       w_lt;
    logic       w_eq;
    logic       w_first_lt;
    logic       w_any_diff;
    logic       w_load;
    logic       w_res_upd;
    logic       w_less_nxt;
    logic       w_equal_nxt;

    assign w_a_byte   = r_a[r_idx];
    assign w_b_byte   = r_b[r_idx];
    assign w_lt       = w_a_byte < w_b_byte;
    assign w_eq       = w_a_byte == w_b_byte;
    // The first difference seen (most significant) decides the ordering.
    assign w_first_lt = r_seen ? r_lt_sticky : w_lt;
    assign w_any_diff = r_seen | ~w_eq;

    // Next-state, operand load and result-update decode; flush overrides all.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_res_upd   = 1'b0;
        w_less_nxt  = r_less;
        w_equal_nxt = r_equal;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                if (!w_eq && (EARLY_EXIT != 0)) begin
                    w_res_upd   = 1'b1;
                    w_less_nxt  = w_lt;
                    w_equal_nxt = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (r_idx == '0) begin
                    w_res_upd   = 1'b1;
                    w_less_nxt  = w_first_lt;
                    w_equal_nxt = ~w_any_diff;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (bus.i_flush) begin
            w_state_nxt = S_IDLE;
            w_load      = 1'b0;
            w_res_upd   = 1'b0;
        end
    end

    // State register, operand capture, byte walk, sticky flag and results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_seen      <= 1'b0;
            r_lt_sticky <= 1'b0;
            r_less      <= 1'b0;
            r_equal     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_a         <= bus.i_data_a;
                r_b         <= bus.i_data_b;
                r_idx       <= W_IDX'(NUM_CHUNK - 1);
                r_seen      <= 1'b0;
                r_lt_sticky <= 1'b0;
            end else if (r_state == S_CMP && !bus.i_flush) begin
                if (!w_eq && !r_seen) begin
                    r_seen      <= 1'b1;
                    r_lt_sticky <= w_lt;
                end
                if (r_idx != '0) begin
                    r_idx <= r_idx - 1'b1;
                end
            end
            if (w_res_upd) begin
                r_less  <= w_less_nxt;
                r_equal <= w_equal_nxt;
            end
        end
    end

    assign bus.o_ready = (r_state == S_IDLE);
    assign bus.o_busy  = (r_state == S_CMP) || (r_state == S_DONE);
    // A flush in the DONE cycle suppresses the pulse as well.
    assign bus.o_valid = (r_state == S_DONE) && !bus.i_flush;
    assign bus.o_less  = r_less;
    assign bus.o_equal = r_equal;
endmodule

// File: tb/tb_fpu_mag_comp_seq.sv
// Bench for fpu_mag_comp_seq: one early-exit and one fixed-latency instance
// driven with identical stimulus.
module tb_fpu_mag_comp_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_mag_comp_seq_if #(.SIZE_DATA(32)) bus1 ();
    fpu_mag_comp_seq_if #(.SIZE_DATA(32)) bus0 ();

    fpu_mag_comp_seq #(.SIZE_DATA(32), .EARLY_EXIT(1)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    fpu_mag_comp_seq #(.SIZE_DATA(32), .EARLY_EXIT(0)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        less;
        logic        equal;
        int          k1;
        int          k0;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } pend_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bytes examined: up to and including the first differing byte from the
    // top when early exit is on, otherwise always all four.
    function automatic int model_k(input logic [31:0] a, input logic [31:0] b, input bit ee);
        if (!ee) return 4;
        for (int i = 3; i >= 0; i--) begin
            if (a[8*i +: 8] != b[8*i +: 8]) return 4 - i;
        end
        return 4;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic st, input logic fl);
        bus1.i_data_a = a; bus1.i_data_b = b; bus1.i_start = st; bus1.i_flush = fl;
        bus0.i_data_a = a; bus0.i_data_b = b; bus0.i_start = st; bus0.i_flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_compare(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic el, input logic ee, input int k1, input int k0);
        int lat1 = -1, lat0 = -1, nv1 = 0, nv0 = 0, nb1 = 0, nb0 = 0, rdy1 = -1, rdy0 = -1;
        logic l1 = 1'b0, e1 = 1'b0, l0 = 1'b0, e0 = 1'b0;
        drive(a, b, 1'b1, 1'b0);
        tick();
        drive($urandom, $urandom, 1'b0, 1'b0);
        if (bus1.o_busy) nb1++;
        if (bus0.o_busy) nb0++;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (bus1.o_valid) begin
                nv1++;
                if (lat1 < 0) begin lat1 = c; l1 = bus1.o_less; e1 = bus1.o_equal; end
            end
            if (bus0.o_valid) begin
                nv0++;
                if (lat0 < 0) begin lat0 = c; l0 = bus0.o_less; e0 = bus0.o_equal; end
            end
            if (bus1.o_busy) nb1++;
            if (bus0.o_busy) nb0++;
            if (lat1 >= 0 && rdy1 < 0 && bus1.o_ready) rdy1 = c;
            if (lat0 >= 0 && rdy0 < 0 && bus0.o_ready) rdy0 = c;
        end
        chk({name, " ee1 latency"}, lat1, k1);
        chk({name, " ee1 valid count"}, nv1, 1);
        chk({name, " ee1 less"}, l1, el);
        chk({name, " ee1 equal"}, e1, ee);
        chk({name, " ee1 busy cycles"}, nb1, k1 + 1);
        chk({name, " ee1 ready edge"}, rdy1, k1 + 1);
        chk({name, " ee0 latency"}, lat0, k0);
        chk({name, " ee0 valid count"}, nv0, 1);
        chk({name, " ee0 less"}, l0, el);
        chk({name, " ee0 equal"}, e0, ee);
        chk({name, " ee0 busy cycles"}, nb0, k0 + 1);
        chk({name, " ee0 ready edge"}, rdy0, k0 + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[9];
        pend_t       q1[$];
        pend_t       q0[$];
        int          nxt1, nxt0, k;
        logic [31:0] a, b;
        logic        st, v1e, v0e;

        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b1, 1'b0, 1, 4};
        vecs[1] = '{32'hC0490FDB, 32'hC0490FDB, 1'b0, 1'b1, 4, 4};
        vecs[2] = '{32'h12345679, 32'h12345678, 1'b0, 1'b0, 4, 4};
        vecs[3] = '{32'h12345678, 32'h12345679, 1'b1, 1'b0, 4, 4};
        vecs[4] = '{32'h01000000, 32'h00FFFFFF, 1'b0, 1'b0, 1, 4};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 4, 4};
        vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1, 4};
        vecs[7] = '{32'h12340000, 32'h12350000, 1'b1, 1'b0, 2, 4};
        vecs[8] = '{32'h00001000, 32'h00001100, 1'b1, 1'b0, 3, 4};

        rst = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk("reset ready", bus1.o_ready, 1'b1);
        chk("reset busy", bus1.o_busy, 1'b0);
        chk("reset valid", bus1.o_valid, 1'b0);
        chk("reset less", bus1.o_less, 1'b0);
        chk("reset equal", bus1.o_equal, 1'b0);
        chk("reset ee0 ready", bus0.o_ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            do_compare($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                       vecs[i].less, vecs[i].equal, vecs[i].k1, vecs[i].k0);
        end

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = a;
            else if (i % 3 == 1) b = a ^ (32'd1 << $urandom_range(0, 31));
            do_compare($sformatf("rand%0d", i), a, b, a < b, a == b,
                       model_k(a, b, 1'b1), model_k(a, b, 1'b0));
        end

        // Start held high with operands changing every cycle.
        nxt1 = 0;
        nxt0 = 0;
        for (int e = 0; e < 80; e++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? (a ^ (32'd1 << $urandom_range(0, 31))) : $urandom;
            st = (e < 60);
            drive(a, b, st, 1'b0);
            if (st && e >= nxt1) begin
                k = model_k(a, b, 1'b1);
                q1.push_back('{a, b, e + k});
                nxt1 = e + k + 2;
            end
            if (st && e >= nxt0) begin
                k = model_k(a, b, 1'b0);
                q0.push_back('{a, b, e + k});
                nxt0 = e + k + 2;
            end
            tick();
            v1e = (q1.size() > 0) && (q1[0].due == e);
            v0e = (q0.size() > 0) && (q0[0].due == e);
            chk($sformatf("stream ee1 valid e%0d", e), bus1.o_valid, v1e);
            chk($sformatf("stream ee0 valid e%0d", e), bus0.o_valid, v0e);
            if (v1e) begin
                chk("stream ee1 less", bus1.o_less, q1[0].a < q1[0].b);
                chk("stream ee1 equal", bus1.o_equal, q1[0].a == q1[0].b);
                void'(q1.pop_front());
            end
            if (v0e) begin
                chk("stream ee0 less", bus0.o_less, q0[0].a < q0[0].b);
                chk("stream ee0 equal", bus0.o_equal, q0[0].a == q0[0].b);
                void'(q0.pop_front());
            end
            chk($sformatf("stream ee1 ready e%0d", e), bus1.o_ready, (e + 1) >= nxt1);
            chk($sformatf("stream ee0 ready e%0d", e), bus0.o_ready, (e + 1) >= nxt0);
        end
        chk("stream ee1 drained", q1.size(), 0);
        chk("stream ee0 drained", q0.size(), 0);

        // Flush and start together in IDLE: start is dropped.
        drive(32'h1, 32'h2, 1'b1, 1'b1);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        chk("flush+start ready", bus1.o_ready, 1'b1);
        chk("flush+start busy", bus1.o_busy, 1'b0);

        // Prior result less=1, then an equal compare flushed at E2.
        do_compare("pre-flush", 32'h00000001, 32'h00000002, 1'b1, 1'b0, 4, 4);
        drive(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b1);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        chk("flush ready", bus1.o_ready, 1'b1);
        chk("flush ee0 ready", bus0.o_ready, 1'b1);
        chk("flush less kept", bus1.o_less, 1'b1);
        chk("flush equal kept", bus1.o_equal, 1'b0);
        chk("flush ee0 less kept", bus0.o_less, 1'b1);
        k = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus1.o_valid || bus0.o_valid) k++;
            tick();
        end
        chk("flush no valid", k, 0);

        // Same sequence with reset at E2.
        drive(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b0);
        tick();
        drive('0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst-mid ready", bus1.o_ready, 1'b1);
        chk("rst-mid busy", bus1.o_busy, 1'b0);
        chk("rst-mid valid", bus1.o_valid, 1'b0);
        chk("rst-mid less", bus1.o_less, 1'b0);
        chk("rst-mid equal", bus1.o_equal, 1'b0);
        chk("rst-mid ee0 less", bus0.o_less, 1'b0);
        k = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus1.o_valid || bus0.o_valid) k++;
            tick();
        end
        chk("rst-mid no valid", k, 0);

        do_compare("post-rst", 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_mag_comp_seq.md
# fpu_mag_comp_seq

Sequential magnitude comparator controller for the FPU add/sub path. It orders two unsigned operand magnitudes, {exponent, mantissa}, by stepping one shared 8-bit less/equal compare slice from the most significant byte down. It stops early on the first unequal byte. The result (o_less, o_equal) drives operand swap/alignment in the adder front end, which hands over operands with a start/ready handshake and receives a one-cycle result-valid pulse.

## Interface
- SIZE_DATA, 32: operand width in bits; must be a multiple of 8 and at least 8.
- EARLY_EXIT, 1: 1 terminates on the first unequal byte; 0 always examines every byte (fixed latency).
- NUM_CHUNK, SIZE_DATA/8: derived localparam, not overridable.
- i_clk  in  1  clock, all state updates on the rising edge.
- i_rst  in  1  reset; one clock; reset is synchronous and active-high.
- i_start  in  1  request a compare; honoured only while o_ready=1.
- i_flush  in  1  synchronous abort; returns to IDLE with no result.
- i_data_a  in  SIZE_DATA  operand A magnitude, sampled with an accepted start.
- i_data_b  in  SIZE_DATA  operand B magnitude, sampled with an accepted start.
- o_ready  out  1  high in IDLE only.
- o_busy  out  1  high in CMP and DONE.
- o_valid  out  1  one-cycle pulse; result outputs are valid.
- o_less  out  1  A < B (unsigned), registered.
- o_equal  out  1  A == B, registered.

## Operation
- States are IDLE, CMP and DONE, held in a registered state variable. Byte index idx counts NUM_CHUNK-1 down to 0.
- IDLE:
  - o_ready=1.
  - On i_start=1: capture A and B into internal registers, set idx=NUM_CHUNK-1 and go to CMP.
  - Otherwise stay in IDLE.
- CMP:
  - Compare byte idx of the captured operands: lt = a_byte < b_byte, eq = a_byte == b_byte. The compare is combinational, 8-bit, bits [8*idx+7 : 8*idx].
  - If !eq and EARLY_EXIT=1: register o_less=lt, o_equal=0, go to DONE.
  - If !eq and EARLY_EXIT=0: latch lt into a sticky first-difference flag if no difference has been seen yet. Later bytes must not change that flag.
  - If idx==0: register the final result and go to DONE. The final result is o_less = sticky lt (or lt of this byte if it is the first difference), and o_equal=1 if no byte differed.
  - Otherwise decrement idx and stay in CMP.
- DONE: o_valid=1 for exactly this cycle, then go to IDLE.
- o_less and o_equal hold their last value until the next result is registered. Consumers qualify them with o_valid.
- o_less and o_equal are never both 1.
- i_start while o_ready=0 is ignored, with no queuing. Operand inputs are don't-care outside an accepted start.
- i_flush:
  - In any state, the next state is IDLE, o_valid is not asserted and the result registers are unchanged.
  - i_flush has priority over i_start in the same cycle: the start is not accepted.
- i_rst has priority over everything: state=IDLE, idx=0, operand registers=0, sticky flag cleared.

## Timing
- Reset values: o_ready=1, o_busy=0, o_valid=0, o_less=0, o_equal=0.
- Call the edge that samples an accepted start E0.
- If k bytes are examined (1 ≤ k ≤ NUM_CHUNK), the result registers update at edge Ek.
- o_valid is high from Ek to Ek+1.
- o_ready is high again after Ek+1.
- Start-to-valid latency is k cycles. It is NUM_CHUNK cycles when EARLY_EXIT=0 or the operands are equal.
- Minimum start-to-start spacing is k+2 edges.
- Back-to-back: i_start held high is accepted again on the first IDLE cycle after DONE.
- Reset mid-compare (in CMP or DONE) discards the operation: no o_valid, outputs return to their reset values on the next edge.

## Test plan
- Reset, then A=0x3F800000 and B=0x40000000 with one start:
  - o_valid one cycle after E1.
  - o_less=1, o_equal=0.
  - o_ready returns at E2.
- A=B=0xC0490FDB:
  - o_valid at E4 with o_equal=1, o_less=0.
  - o_busy high for exactly 5 cycles, E0 through E5.
- A=0x12345679 vs B=0x12345678 (LSB differs only):
  - Latency 4, o_less=0, o_equal=0.
  - Swap the operands: o_less=1.
- EARLY_EXIT=0, A=0x01000000, B=0x00FFFFFF:
  - o_valid at E4, not E1.
  - o_less=0; the sticky flag is not overwritten by the lower bytes where A<B.
- Start asserted every cycle with changing operands: only starts sampled in IDLE are accepted; each result matches the operands captured at its own E0.
- Flush and reset:
  - i_flush pulsed at E2 of a 4-byte compare: no o_valid, o_ready=1 after E2, prior o_less/o_equal retained.
  - Same check with i_rst: outputs are 0 after the edge.
